// File: rtl/regfile_pkg.sv
// Shared sizing, types and FSM state encoding for the register-file port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a; the controller's Busy output is the only stall signal.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;

  typedef logic [ADDR_W-1:0]   reg_idx_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] wordline_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_onehot_decoder.sv
// Register index to one-hot wordline decoder with an enable.
// Latency: combinational.
// Backpressure: none; all-zero output when disabled so no register drives or latches.
module regfile_onehot_decoder
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // At most one bit set, and only when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Port-side controller for the bit-cell register array: wordlines, write data, read muxing,
// write-to-read bypass, R0 hardwiring and a post-reset clear sweep. Reads are combinational.
// Busy is high during reset and the clear sweep; upstream stalls and WriteReg is ignored then.
module regfile_port_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   SrcReg1,
  input  logic [ADDR_W-1:0]   SrcReg2,
  input  logic [ADDR_W-1:0]   DstReg,
  input  logic                WriteReg,
  input  logic [DATA_W-1:0]   DstData,
  output logic [NUM_REGS-1:0] WriteWordline,
  output logic [NUM_REGS-1:0] ReadWordline1,
  output logic [NUM_REGS-1:0] ReadWordline2,
  output logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W-1:0]   Bitline1,
  input  logic [DATA_W-1:0]   Bitline2,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  output logic                Busy
);

  state_t   state;
  reg_idx_t clr_idx;

  logic     running;
  logic     clearing;
  reg_idx_t wr_addr;
  logic     wr_en;
  logic     rd1_en;
  logic     rd2_en;

  // Clear sweep starts at R1 (R0 is hardwired) and ends at the last register, then RUN forever
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= reg_idx_t'(1);
    end else if (state == CLEAR) begin
      if (clr_idx == reg_idx_t'(NUM_REGS - 1)) begin
        state <= RUN;
      end else begin
        clr_idx <= clr_idx + reg_idx_t'(1);
      end
    end
  end

  // Reset overrides the state so the reset cycle itself drives nothing onto the array
  assign running  = (state == RUN) && !rst;
  assign clearing = (state == CLEAR) && !rst;
  assign Busy     = !running;

  // The clear sweep borrows the write port; functional writes are dropped meanwhile
  assign wr_addr   = clearing ? clr_idx : DstReg;
  assign wr_en     = clearing || (running && WriteReg && (DstReg != '0));
  assign WriteData = running ? DstData : '0;

  // R0 never gets a read wordline, so nothing drives the bus for it
  assign rd1_en = running && (SrcReg1 != '0);
  assign rd2_en = running && (SrcReg2 != '0);

  regfile_onehot_decoder u_wr_dec (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (WriteWordline)
  );

  regfile_onehot_decoder u_rd1_dec (
    .addr   (SrcReg1),
    .en     (rd1_en),
    .onehot (ReadWordline1)
  );

  regfile_onehot_decoder u_rd2_dec (
    .addr   (SrcReg2),
    .en     (rd2_en),
    .onehot (ReadWordline2)
  );

  // Operand select: zero when idle or R0 (bus may float), else bypass, else bitline
  always_comb begin
    SrcData1 = '0;
    if (rd1_en) begin
      if (WriteReg && (DstReg == SrcReg1)) SrcData1 = DstData;
      else                                 SrcData1 = Bitline1;
    end
    SrcData2 = '0;
    if (rd2_en) begin
      if (WriteReg && (DstReg == SrcReg2)) SrcData2 = DstData;
      else                                 SrcData2 = Bitline2;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a small bit-cell array model driving the bitlines.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Busy is checked every clear cycle; no waits depend on DUT events.
module tb_regfile_port_ctrl;
  import regfile_pkg::*;

  logic                clk;
  logic                rst;
  logic [ADDR_W-1:0]   SrcReg1;
  logic [ADDR_W-1:0]   SrcReg2;
  logic [ADDR_W-1:0]   DstReg;
  logic                WriteReg;
  logic [DATA_W-1:0]   DstData;
  logic [NUM_REGS-1:0] WriteWordline;
  logic [NUM_REGS-1:0] ReadWordline1;
  logic [NUM_REGS-1:0] ReadWordline2;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W-1:0]   Bitline1;
  logic [DATA_W-1:0]   Bitline2;
  logic [DATA_W-1:0]   SrcData1;
  logic [DATA_W-1:0]   SrcData2;
  logic                Busy;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] cells [NUM_REGS];

  regfile_port_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .SrcReg1       (SrcReg1),
    .SrcReg2       (SrcReg2),
    .DstReg        (DstReg),
    .WriteReg      (WriteReg),
    .DstData       (DstData),
    .WriteWordline (WriteWordline),
    .ReadWordline1 (ReadWordline1),
    .ReadWordline2 (ReadWordline2),
    .WriteData     (WriteData),
    .Bitline1      (Bitline1),
    .Bitline2      (Bitline2),
    .SrcData1      (SrcData1),
    .SrcData2      (SrcData2),
    .Busy          (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-cell array: each cell latches WriteData on its write wordline
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WriteWordline[i]) cells[i] <= WriteData;
    end
  end

  // Bitline buses float unless a read wordline selects a cell
  always_comb begin
    Bitline1 = 'z;
    Bitline2 = 'z;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ReadWordline1[i]) Bitline1 = cells[i];
      if (ReadWordline2[i]) Bitline2 = cells[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks one clear-sweep cycle; WriteReg/DstReg/DstData are driven with junk meanwhile
  task automatic chk_clear_cycle(input int c);
    logic [NUM_REGS-1:0] exp_wl;
    @(negedge clk);
    exp_wl = '0;
    exp_wl[c] = 1'b1;
    chk($sformatf("clr%0d_busy", c), {31'd0, Busy}, 32'd1);
    chk($sformatf("clr%0d_wwl", c), {16'd0, WriteWordline}, {16'd0, exp_wl});
    chk($sformatf("clr%0d_wdata", c), {16'd0, WriteData}, 32'h0);
    chk($sformatf("clr%0d_rwl1", c), {16'd0, ReadWordline1}, 32'h0);
    chk($sformatf("clr%0d_src1", c), {16'd0, SrcData1}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NUM_REGS; i++) cells[i] = 16'hDEAD;

    // Reset held for two edges, with a write request and reads that must be ignored
    rst      = 1'b1;
    SrcReg1  = 4'd5;
    SrcReg2  = 4'd6;
    WriteReg = 1'b1;
    DstReg   = 4'd9;
    DstData  = 16'hAAAA;
    next_cycle();
    @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    chk("rst_wwl", {16'd0, WriteWordline}, 32'h0);
    chk("rst_wdata", {16'd0, WriteData}, 32'h0);
    chk("rst_rwl1", {16'd0, ReadWordline1}, 32'h0);
    chk("rst_rwl2", {16'd0, ReadWordline2}, 32'h0);
    chk("rst_src1", {16'd0, SrcData1}, 32'h0);
    chk("rst_src2", {16'd0, SrcData2}, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Clear sweep R1..R15 while writes to R9 are requested
    for (int c = 1; c < NUM_REGS; c++) chk_clear_cycle(c);

    // 16th cycle after release: RUN
    WriteReg = 1'b0;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd0;
    @(negedge clk);
    chk("run_busy", {31'd0, Busy}, 32'd0);
    chk("run_wwl_idle", {16'd0, WriteWordline}, 32'h0);
    chk("run_r9_cleared", {16'd0, cells[9]}, 32'h0);
    chk("run_r15_cleared", {16'd0, cells[15]}, 32'h0);

    // Write R5 = BEEF
    next_cycle();
    WriteReg = 1'b1;
    DstReg   = 4'd5;
    DstData  = 16'hBEEF;
    @(negedge clk);
    chk("wr5_wwl", {16'd0, WriteWordline}, 32'h0020);
    chk("wr5_wdata", {16'd0, WriteData}, 32'hBEEF);

    // Read R5 from the cell on port 1
    next_cycle();
    WriteReg = 1'b0;
    SrcReg1  = 4'd5;
    @(negedge clk);
    chk("rd5_rwl1", {16'd0, ReadWordline1}, 32'h0020);
    chk("rd5_src1", {16'd0, SrcData1}, 32'hBEEF);
    chk("rd5_rwl2_r0", {16'd0, ReadWordline2}, 32'h0);
    chk("rd5_src2_r0", {16'd0, SrcData2}, 32'h0);

    // Same-cycle bypass to both ports; R3 cells still hold the cleared 0
    next_cycle();
    WriteReg = 1'b1;
    DstReg   = 4'd3;
    DstData  = 16'h1234;
    SrcReg1  = 4'd3;
    SrcReg2  = 4'd3;
    @(negedge clk);
    chk("byp_wwl", {16'd0, WriteWordline}, 32'h0008);
    chk("byp_rwl1", {16'd0, ReadWordline1}, 32'h0008);
    chk("byp_rwl2", {16'd0, ReadWordline2}, 32'h0008);
    chk("byp_src1", {16'd0, SrcData1}, 32'h1234);
    chk("byp_src2", {16'd0, SrcData2}, 32'h1234);

    // Distinct ports, data now from the cells; a write to R7 must not bypass
    next_cycle();
    WriteReg = 1'b1;
    DstReg   = 4'd7;
    DstData  = 16'h5555;
    SrcReg1  = 4'd3;
    SrcReg2  = 4'd5;
    @(negedge clk);
    chk("rd_both_src1", {16'd0, SrcData1}, 32'h1234);
    chk("rd_both_src2", {16'd0, SrcData2}, 32'hBEEF);
    chk("rd_both_rwl2", {16'd0, ReadWordline2}, 32'h0020);

    // R0: write is dropped and read returns 0 with a floating bitline
    next_cycle();
    WriteReg = 1'b1;
    DstReg   = 4'd0;
    DstData  = 16'hFFFF;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd7;
    @(negedge clk);
    chk("r0_wwl", {16'd0, WriteWordline}, 32'h0);
    chk("r0_rwl1", {16'd0, ReadWordline1}, 32'h0);
    chk("r0_src1", {16'd0, SrcData1}, 32'h0);
    chk("r7_src2", {16'd0, SrcData2}, 32'h5555);
    next_cycle();
    WriteReg = 1'b0;
    @(negedge clk);
    chk("r0_after_src1", {16'd0, SrcData1}, 32'h0);

    // Reset from RUN, then reset again in the middle of the sweep at clr_idx=7
    next_cycle();
    rst      = 1'b1;
    WriteReg = 1'b1;
    DstReg   = 4'd9;
    DstData  = 16'hAAAA;
    next_cycle();
    rst = 1'b0;
    for (int c = 1; c < 7; c++) chk_clear_cycle(c);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, Busy}, 32'd1);
    chk("midrst_wwl", {16'd0, WriteWordline}, 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 1; c < NUM_REGS; c++) chk_clear_cycle(c);
    WriteReg = 1'b0;
    @(negedge clk);
    chk("midrst_run_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_r5_cleared", {16'd0, cells[5]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
